rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- In-order reorder buffer and commit stage, directly upstream of the integer register file.
- Decode allocates one entry per instruction in program order; execution units return results out of order on a single result bus.
- The oldest completed entry retires once per cycle and drives the register-file write port (write enable, write address, write data).
- A flush empties the buffer on mispredict.

Parameters:
- XLEN, 32, data width of result and commit write data
- DEPTH, 8, number of entries; power of two, at least 2
- TAG_W, $clog2(DEPTH), width of entry tag

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  decode requests an entry
- alloc_rd  in  5  destination register of the allocating instruction
- alloc_ready  out  1  entry available (not full)
- alloc_tag  out  TAG_W  tag granted on an accepted allocation (current tail index)
- cdb_valid  in  1  result bus valid
- cdb_tag  in  TAG_W  tag of the completing entry
- cdb_data  in  XLEN  result value
- flush  in  1  discard all entries
- commit_we  out  1  register-file write enable
- commit_wa  out  5  register-file write address
- commit_wd  out  XLEN  register-file write data
- empty  out  1  no valid entries
- full  out  1  DEPTH valid entries

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high, on port reset. Everything updates on the rising edge of clk.
- State per entry: valid, ready, rd[4:0], data[XLEN-1:0].
- Pointers: head and tail are TAG_W+1 bits wide, with the MSB used as a wrap bit.
  - empty = (head == tail)
  - full = (index bits equal) && (wrap bits differ)
- Allocate: fires when alloc_valid && !full.
  - Entry[tail] gets valid=1, ready=0, rd=alloc_rd.
  - tail increments, modulo 2*DEPTH.
  - alloc_ready = !full, computed combinationally from current state only. A same-cycle commit does not free a slot for a same-cycle allocation.
- Result: fires when cdb_valid and entry[cdb_tag].valid.
  - Entry gets ready=1 and data=cdb_data.
  - cdb_valid to an invalid entry is ignored. No error is raised.
- Commit: fires when entry[head] is valid and ready.
  - At the edge: entry[head].valid is cleared and head increments.
  - commit_we <= (rd != 0), commit_wa <= rd, commit_wd <= data.
  - When no commit fires: commit_we <= 0; commit_wa and commit_wd hold their values.
  - Commit outputs are registered. A cdb_valid accepted at edge N for the head entry gives commit_we=1 in the cycle after edge N+1, i.e. 2 cycles of latency.
- Commit rate: at most one commit per cycle. In-order commit: a ready younger entry waits behind a not-ready head.
- Simultaneous events:
  - Allocate, result and commit may all occur in the same cycle.
  - A result to the head entry in cycle N does not commit until the next cycle.
- Flush:
  - At the edge: all valid bits cleared, head=tail=0, commit_we <= 0.
  - Overrides allocate, result and commit in the same cycle.
- Reset: same as flush. In addition commit_wa=0 and commit_wd=0.
  - After reset: alloc_ready=1, alloc_tag=0, empty=1, full=0, commit_we=0.
  - Reset asserted mid-operation discards in-flight entries without committing them.

Optional Feature:
- Macro: ROB_FWD_EN.
- Defined: adds operand forwarding.
  - Added ports: fwd_rs in 5, fwd_hit out 1, fwd_pending out 1, fwd_data out XLEN.
  - Combinational search, newest to oldest (tail-1 back to head), for a valid entry with rd == fwd_rs and fwd_rs != 0.
  - fwd_hit=1 if such an entry is found.
  - fwd_pending = !ready of that entry.
  - fwd_data = that entry's data; 0 when there is no hit.
- Undefined: these ports and the search logic are absent.

Decomposition:
- Package rob_pkg holds:
  - XLEN_DEF and ROB_DEPTH_DEF constants
  - rob_entry_t packed struct {valid, ready, rd, data}
  - rob_tag_t typedef
- Sub-module rob_fwd_search (ROB_FWD_EN only): priority search over the entry array given head and tail.

Test Plan:
- Reset, then allocate rd=5 (tag 0), then cdb tag0 data 0xDEADBEEF -> 2 cycles later commit_we=1, commit_wa=5, commit_wd=0xDEADBEEF; empty=1 afterwards.
- Allocate rd=1,2,3; complete tags 2,1 then 0 -> commits occur in order 1,2,3 on consecutive cycles, and none before tag 0 completes.
- Allocate 8 entries -> full=1, alloc_ready=0, a 9th request is ignored; commit one, then allocate -> the new entry gets tag 0 (wrap-around) and full returns to 1.
- Allocate rd=0 and complete it -> it commits with commit_we=0 and head advances.
- 4 entries pending, assert flush together with cdb_valid and alloc_valid -> next cycle empty=1, commit_we=0, alloc_tag=0; a later cdb to an old tag is ignored.
- ROB_FWD_EN: two entries with rd=7, older ready with data 0x11, younger not ready, fwd_rs=7 -> fwd_hit=1, fwd_pending=1; complete the younger with 0x22 -> fwd_pending=0, fwd_data=0x22.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and default sizes for the reorder buffer / commit stage.
package rob_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int ROB_DEPTH_DEF = 8;
   localparam int ROB_TAG_W_DEF = $clog2(ROB_DEPTH_DEF);

   // Tag naming one ROB slot at the default depth.
   typedef logic [ROB_TAG_W_DEF-1:0] rob_tag_t;

   // One ROB slot at the default data width.
   typedef struct packed {
      logic                valid;
      logic                ready;
      logic [4:0]          rd;
      logic [XLEN_DEF-1:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_fwd_search.sv
// Operand-forwarding search over the ROB entries (built only with ROB_FWD_EN).
// Scans from head (oldest) to tail-1 (newest); the last match seen wins,
// so the newest producer of the requested register is reported.
`ifdef ROB_FWD_EN
module rob_fwd_search
   import rob_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = ROB_DEPTH_DEF,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]           valid_i,
   input  logic [DEPTH-1:0]           ready_i,
   input  logic [DEPTH-1:0][4:0]      rd_i,
   input  logic [DEPTH-1:0][XLEN-1:0] data_i,
   input  logic [TAG_W:0]             head_i,
   input  logic [TAG_W:0]             tail_i,
   input  logic [4:0]                 rs_i,
   output logic                       hit_o,
   output logic                       pending_o,
   output logic [XLEN-1:0]            data_o
);

   logic [TAG_W:0]   cnt;
   logic [TAG_W-1:0] idx;

   // Age-ordered scan; later (younger) matches overwrite earlier ones.
   always_comb begin
      hit_o     = 1'b0;
      pending_o = 1'b0;
      data_o    = '0;
      idx       = '0;
      cnt       = tail_i - head_i;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_i[TAG_W-1:0] + TAG_W'(i);
         if (((TAG_W+1)'(i) < cnt) && valid_i[idx] &&
             (rd_i[idx] == rs_i) && (rs_i != 5'd0)) begin
            hit_o     = 1'b1;
            pending_o = !ready_i[idx];
            data_o    = data_i[idx];
         end
      end
   end

endmodule
`endif

// File: rtl/rob_commit.sv
// In-order reorder buffer and commit stage feeding the integer register file.
// Entries are allocated at the tail in program order, completed out of order
// from a single result bus, and retired one per cycle from the head through a
// registered write port. Optional operand forwarding is enabled by ROB_FWD_EN.
module rob_commit
   import rob_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = ROB_DEPTH_DEF,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             alloc_valid,
   input  logic [4:0]       alloc_rd,
   output logic             alloc_ready,
   output logic [TAG_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   input  logic             flush,
`ifdef ROB_FWD_EN
   input  logic [4:0]       fwd_rs,
   output logic             fwd_hit,
   output logic             fwd_pending,
   output logic [XLEN-1:0]  fwd_data,
`endif
   output logic             commit_we,
   output logic [4:0]       commit_wa,
   output logic [XLEN-1:0]  commit_wd,
   output logic             empty,
   output logic             full
);

   localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [TAG_W:0]   head_q, head_d;
   logic [TAG_W:0]   tail_q, tail_d;
   logic [TAG_W-1:0] head_idx, tail_idx;

   // Entry storage.
   logic [DEPTH-1:0]           valid_q;
   logic [DEPTH-1:0]           ready_q;
   logic [DEPTH-1:0][4:0]      rd_q;
   logic [DEPTH-1:0][XLEN-1:0] data_q;

   // Registered register-file write port.
   logic            commit_we_q, commit_we_d;
   logic [4:0]      commit_wa_q, commit_wa_d;
   logic [XLEN-1:0] commit_wd_q, commit_wd_d;

   logic alloc_fire, cdb_fire, commit_fire;
   logic empty_w, full_w;

   assign head_idx = head_q[TAG_W-1:0];
   assign tail_idx = tail_q[TAG_W-1:0];

   assign empty_w = (head_q == tail_q);
   assign full_w  = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

   // Flush wins over every other event in the same cycle. Commit looks only at
   // registered ready, so a result arriving for the head retires a cycle later,
   // and a slot freed by a commit is not reusable until the following cycle.
   assign alloc_fire  = alloc_valid && !full_w && !flush;
   assign cdb_fire    = cdb_valid && valid_q[cdb_tag] && !flush;
   assign commit_fire = valid_q[head_idx] && ready_q[head_idx] && !flush;

   // Next-state for pointers and the commit write port.
   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      commit_we_d = 1'b0;
      commit_wa_d = commit_wa_q;
      commit_wd_d = commit_wd_q;
      if (alloc_fire) begin
         tail_d = tail_q + PTR_ONE;
      end
      if (commit_fire) begin
         head_d      = head_q + PTR_ONE;
         commit_we_d = (rd_q[head_idx] != 5'd0);
         commit_wa_d = rd_q[head_idx];
         commit_wd_d = data_q[head_idx];
      end
   end

   // Pointer registers; reset and flush both rewind to slot 0.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head_q <= '0;
         tail_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   // Valid bits: set on allocate, cleared on commit, wiped on reset/flush.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid_q <= '0;
      end else begin
         if (alloc_fire) begin
            valid_q[tail_idx] <= 1'b1;
         end
         if (commit_fire) begin
            valid_q[head_idx] <= 1'b0;
         end
      end
   end

   // Entry payload; meaningful only while the slot's valid bit is set.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         ready_q[tail_idx] <= 1'b0;
         rd_q[tail_idx]    <= alloc_rd;
      end
      if (cdb_fire) begin
         ready_q[cdb_tag] <= 1'b1;
         data_q[cdb_tag]  <= cdb_data;
      end
   end

   // Commit port; flush only drops the enable, reset also clears address/data.
   always_ff @(posedge clk) begin
      if (reset) begin
         commit_we_q <= 1'b0;
         commit_wa_q <= '0;
         commit_wd_q <= '0;
      end else if (flush) begin
         commit_we_q <= 1'b0;
      end else begin
         commit_we_q <= commit_we_d;
         commit_wa_q <= commit_wa_d;
         commit_wd_q <= commit_wd_d;
      end
   end

   assign alloc_ready = !full_w;
   assign alloc_tag   = tail_idx;
   assign empty       = empty_w;
   assign full        = full_w;
   assign commit_we   = commit_we_q;
   assign commit_wa   = commit_wa_q;
   assign commit_wd   = commit_wd_q;

`ifdef ROB_FWD_EN
   rob_fwd_search #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_fwd (
      .valid_i   (valid_q),
      .ready_i   (ready_q),
      .rd_i      (rd_q),
      .data_i    (data_q),
      .head_i    (head_q),
      .tail_i    (tail_q),
      .rs_i      (fwd_rs),
      .hit_o     (fwd_hit),
      .pending_o (fwd_pending),
      .data_o    (fwd_data)
   );
`endif

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: stimulus pushes expected commits (address,
// data, cycle) into a queue; a monitor pops and compares on every commit_we.
// Forwarding checks are included when ROB_FWD_EN is defined.
module tb_rob_commit;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic        alloc_ready;
   logic [2:0]  alloc_tag;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        flush;
   logic        commit_we;
   logic [4:0]  commit_wa;
   logic [31:0] commit_wd;
   logic        empty;
   logic        full;
`ifdef ROB_FWD_EN
   logic [4:0]  fwd_rs;
   logic        fwd_hit;
   logic        fwd_pending;
   logic [31:0] fwd_data;
`endif

   rob_commit dut (
      .clk         (clk),
      .reset       (reset),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .alloc_ready (alloc_ready),
      .alloc_tag   (alloc_tag),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .cdb_data    (cdb_data),
      .flush       (flush),
`ifdef ROB_FWD_EN
      .fwd_rs      (fwd_rs),
      .fwd_hit     (fwd_hit),
      .fwd_pending (fwd_pending),
      .fwd_data    (fwd_data),
`endif
      .commit_we   (commit_we),
      .commit_wa   (commit_wa),
      .commit_wd   (commit_wd),
      .empty       (empty),
      .full        (full)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write-enabled commit must match the oldest expectation.
   always @(negedge clk) begin
      if (commit_we === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_commit: got wa=%0d wd=%h at cycle %0d, required no commit",
                     commit_wa, commit_wd, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (commit_wa !== e.wa || commit_wd !== e.wd || cyc != e.cyc) begin
               n_err++;
               $display("FAIL commit: got wa=%0d wd=%h cycle=%0d, required wa=%0d wd=%h cycle=%0d",
                        commit_wa, commit_wd, cyc, e.wa, e.wd, e.cyc);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic exp_commit(input logic [4:0] wa, input logic [31:0] wd, input int c);
      exp_t e;
      e.wa  = wa;
      e.wd  = wd;
      e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic do_alloc(input logic [4:0] rd);
      alloc_valid = 1'b1;
      alloc_rd    = rd;
      tick();
      alloc_valid = 1'b0;
   endtask

   task automatic do_cdb(input logic [2:0] tag, input logic [31:0] data);
      cdb_valid = 1'b1;
      cdb_tag   = tag;
      cdb_data  = data;
      tick();
      cdb_valid = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      alloc_valid = 1'b0;
      alloc_rd    = '0;
      cdb_valid   = 1'b0;
      cdb_tag     = '0;
      cdb_data    = '0;
      flush       = 1'b0;
`ifdef ROB_FWD_EN
      fwd_rs      = '0;
`endif
      repeat (3) tick();

      // Reset state
      check("rst_alloc_ready", alloc_ready, 1);
      check("rst_alloc_tag", alloc_tag, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_commit_we", commit_we, 0);
      check("rst_commit_wa", commit_wa, 0);
      check("rst_commit_wd", commit_wd, 0);
      reset = 1'b0;

      // Single instruction, two-cycle result-to-commit latency
      check("t1_tag", alloc_tag, 0);
      do_alloc(5'd5);
      check("t1_not_empty", empty, 0);
      exp_commit(5'd5, 32'hDEADBEEF, cyc + 2);
      do_cdb(3'd0, 32'hDEADBEEF);
      tick();
      tick();
      check("t1_empty_after", empty, 1);
      check("t1_we_drops", commit_we, 0);

      // Out-of-order completion, in-order commit
      do_reset();
      check("t2_tag0", alloc_tag, 0);
      do_alloc(5'd1);
      check("t2_tag1", alloc_tag, 1);
      do_alloc(5'd2);
      check("t2_tag2", alloc_tag, 2);
      do_alloc(5'd3);
      begin
         int c;
         c = cyc;
         exp_commit(5'd1, 32'h100, c + 4);
         exp_commit(5'd2, 32'h200, c + 5);
         exp_commit(5'd3, 32'h300, c + 6);
      end
      do_cdb(3'd2, 32'h300);
      do_cdb(3'd1, 32'h200);
      check("t2_waiting", empty, 0);
      do_cdb(3'd0, 32'h100);
      repeat (4) tick();
      check("t2_empty_after", empty, 1);

      // Full, ignored 9th request, wrap-around of the tail
      do_reset();
      for (int i = 0; i < 8; i++) do_alloc(5'(8 + i));
      check("t3_full", full, 1);
      check("t3_alloc_ready", alloc_ready, 0);
      check("t3_tag_wrapped", alloc_tag, 0);
      alloc_valid = 1'b1;
      alloc_rd    = 5'd20;
      tick();
      alloc_valid = 1'b0;
      check("t3_still_full", full, 1);
      check("t3_tag_unchanged", alloc_tag, 0);
      exp_commit(5'd8, 32'hA0, cyc + 2);
      do_cdb(3'd0, 32'hA0);
      tick();
      check("t3_not_full", full, 0);
      check("t3_ready_again", alloc_ready, 1);
      check("t3_wrap_tag", alloc_tag, 0);
      do_alloc(5'd21);
      check("t3_full_again", full, 1);
      check("t3_tag_next", alloc_tag, 1);
      for (int i = 1; i < 8; i++) begin
         exp_commit(5'(8 + i), 32'h1000 + 32'(i), cyc + 2);
         do_cdb(3'(i), 32'h1000 + 32'(i));
      end
      exp_commit(5'd21, 32'h2100, cyc + 2);
      do_cdb(3'd0, 32'h2100);
      repeat (2) tick();
      check("t3_empty_after", empty, 1);

      // rd=0 retires silently; alloc, result and commit in one cycle
      do_reset();
      do_alloc(5'd0);
      do_alloc(5'd6);
      do_cdb(3'd0, 32'h55);
      check("t4_tag2", alloc_tag, 2);
      alloc_valid = 1'b1;
      alloc_rd    = 5'd12;
      cdb_valid   = 1'b1;
      cdb_tag     = 3'd1;
      cdb_data    = 32'h66;
      exp_commit(5'd6, 32'h66, cyc + 2);
      tick();
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
      check("t4_rd0_we", commit_we, 0);
      check("t4_rd0_wa", commit_wa, 0);
      check("t4_rd0_wd", commit_wd, 32'h55);
      check("t4_not_empty", empty, 0);
      exp_commit(5'd12, 32'h77, cyc + 2);
      do_cdb(3'd2, 32'h77);
      tick();
      tick();
      check("t4_empty_after", empty, 1);

      // Flush overrides simultaneous commit, result and allocate
      do_reset();
      for (int i = 1; i <= 4; i++) do_alloc(5'(i));
      do_cdb(3'd0, 32'h99);
      flush       = 1'b1;
      cdb_valid   = 1'b1;
      cdb_tag     = 3'd1;
      cdb_data    = 32'h77;
      alloc_valid = 1'b1;
      alloc_rd    = 5'd9;
      tick();
      flush       = 1'b0;
      cdb_valid   = 1'b0;
      alloc_valid = 1'b0;
      check("t5_empty", empty, 1);
      check("t5_full", full, 0);
      check("t5_we", commit_we, 0);
      check("t5_tag", alloc_tag, 0);
      do_cdb(3'd1, 32'hBAD);
      tick();
      tick();
      check("t5_stale_cdb_ignored", empty, 1);
      check("t5_realloc_tag", alloc_tag, 0);
      do_alloc(5'd10);
      exp_commit(5'd10, 32'h88, cyc + 2);
      do_cdb(3'd0, 32'h88);
      tick();
      tick();
      check("t5_empty_after", empty, 1);

      // Reset mid-operation discards a ready entry without committing it
      do_alloc(5'd17);
      do_alloc(5'd18);
      exp_commit(5'd17, 32'h1717, cyc + 2);
      do_cdb(3'd1, 32'h1717);
      do_cdb(3'd2, 32'h1818);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_we", commit_we, 0);
      check("t6_wa", commit_wa, 0);
      check("t6_wd", commit_wd, 0);
      check("t6_empty", empty, 1);
      tick();

`ifdef ROB_FWD_EN
      // Forwarding picks the newest producer of the register
      do_reset();
      do_alloc(5'd7);
      do_alloc(5'd7);
      fwd_rs = 5'd7;
      exp_commit(5'd7, 32'h11, cyc + 2);
      do_cdb(3'd0, 32'h11);
      check("fwd_hit_a", fwd_hit, 1);
      check("fwd_pending_a", fwd_pending, 1);
      exp_commit(5'd7, 32'h22, cyc + 2);
      do_cdb(3'd1, 32'h22);
      check("fwd_hit_b", fwd_hit, 1);
      check("fwd_pending_b", fwd_pending, 0);
      check("fwd_data_b", fwd_data, 32'h22);
      fwd_rs = 5'd3;
      #1;
      check("fwd_miss_hit", fwd_hit, 0);
      check("fwd_miss_data", fwd_data, 0);
      fwd_rs = 5'd0;
      #1;
      check("fwd_x0_hit", fwd_hit, 0);
      tick();
      tick();
      fwd_rs = 5'd7;
      #1;
      check("fwd_after_commit", fwd_hit, 0);
`endif

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
